// File: rtl/grid_scan_counter.sv
// Raster-order lattice coordinate generator for the LBM streaming/collision pipeline.
// Emits {Cell_idx, Row, Col} under a Valid/Enable handshake and counts completed sweeps.
module grid_scan_counter #(
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter int unsigned IDX_WIDTH   = $clog2(GRID_W * GRID_H),
  parameter int unsigned ROW_WIDTH   = $clog2(GRID_H),
  parameter int unsigned COL_WIDTH   = $clog2(GRID_W),
  parameter int unsigned SWEEP_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Dir,
  input  logic                   Continuous,
  input  logic                   Enable,
  output logic [IDX_WIDTH-1:0]   Cell_idx,
  output logic [ROW_WIDTH-1:0]   Row,
  output logic [COL_WIDTH-1:0]   Col,
  output logic                   Valid,
  output logic                   Row_first,
  output logic                   Row_last,
  output logic                   Done,
  output logic                   Busy,
  output logic [SWEEP_WIDTH-1:0] Sweep_count
);

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(GRID_W * GRID_H - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(GRID_H - 1);
  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(GRID_W - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   dir_q, cont_q;
  logic                   start_go, accept, at_last, sweep_end, load_dir;
  logic [IDX_WIDTH-1:0]   first_idx, step_idx;
  logic [ROW_WIDTH-1:0]   first_row, step_row;
  logic [COL_WIDTH-1:0]   first_col, step_col;

  assign start_go  = (state_q == IDLE) && Start && !Stop;
  assign accept    = (state_q == SCAN) && Enable;
  assign at_last   = dir_q ? (Cell_idx == '0) : (Cell_idx == IDX_LAST);
  assign sweep_end = accept && at_last && !Stop;
  // A fresh Start takes its direction from the pin; a continuous wrap reuses the latched one.
  assign load_dir  = (state_q == IDLE) ? Dir : dir_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_go) state_d = SCAN;
      SCAN: begin
        if (Stop)                       state_d = IDLE;
        else if (sweep_end && !cont_q)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // First cell of a sweep and the successor of the current cell
  always_comb begin
    first_idx = load_dir ? IDX_LAST : '0;
    first_row = load_dir ? ROW_LAST : '0;
    first_col = load_dir ? COL_LAST : '0;
    step_idx  = Cell_idx;
    step_row  = Row;
    step_col  = Col;
    if (!dir_q) begin
      step_idx = Cell_idx + IDX_WIDTH'(1);
      if (Col == COL_LAST) begin
        step_col = '0;
        step_row = Row + ROW_WIDTH'(1);
      end else begin
        step_col = Col + COL_WIDTH'(1);
      end
    end else begin
      step_idx = Cell_idx - IDX_WIDTH'(1);
      if (Col == '0) begin
        step_col = COL_LAST;
        step_row = Row - ROW_WIDTH'(1);
      end else begin
        step_col = Col - COL_WIDTH'(1);
      end
    end
  end

  // Registered coordinates, status and sweep counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Cell_idx    <= '0;
      Row         <= '0;
      Col         <= '0;
      Done        <= 1'b0;
      Busy        <= 1'b0;
      Sweep_count <= '0;
      dir_q       <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      Done <= 1'b0;
      Busy <= (state_d == SCAN);
      if (start_go) begin
        dir_q       <= Dir;
        cont_q      <= Continuous;
        Sweep_count <= '0;
        Cell_idx    <= first_idx;
        Row         <= first_row;
        Col         <= first_col;
      end else if (accept && !Stop) begin
        if (at_last) begin
          Done        <= 1'b1;
          Sweep_count <= Sweep_count + SWEEP_WIDTH'(1);
          if (cont_q) begin
            Cell_idx <= first_idx;
            Row      <= first_row;
            Col      <= first_col;
          end
        end else begin
          Cell_idx <= step_idx;
          Row      <= step_row;
          Col      <= step_col;
        end
      end
    end
  end

  // Combinational handshake and row-boundary flags
  always_comb begin
    Valid     = (state_q == SCAN);
    Row_first = dir_q ? (Col == COL_LAST) : (Col == '0);
    Row_last  = dir_q ? (Col == '0) : (Col == COL_LAST);
  end

endmodule

// File: tb/tb_grid_scan_counter.sv
// Directed bench for grid_scan_counter: a 16x16 instance and a 4x3 instance share stimulus.
module tb_grid_scan_counter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0, Stop = 1'b0, Dir = 1'b0, Continuous = 1'b0, Enable = 1'b0;

  logic [7:0] a_idx;  logic [3:0] a_row, a_col;
  logic a_valid, a_rf, a_rl, a_done, a_busy;  logic [7:0] a_sc;
  logic [3:0] b_idx;  logic [1:0] b_row, b_col;
  logic b_valid, b_rf, b_rl, b_done, b_busy;  logic [7:0] b_sc;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  grid_scan_counter u_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Dir(Dir),
    .Continuous(Continuous), .Enable(Enable),
    .Cell_idx(a_idx), .Row(a_row), .Col(a_col), .Valid(a_valid),
    .Row_first(a_rf), .Row_last(a_rl), .Done(a_done), .Busy(a_busy), .Sweep_count(a_sc)
  );

  grid_scan_counter #(.GRID_W(4), .GRID_H(3)) u_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Dir(Dir),
    .Continuous(Continuous), .Enable(Enable),
    .Cell_idx(b_idx), .Row(b_row), .Col(b_col), .Valid(b_valid),
    .Row_first(b_rf), .Row_last(b_rl), .Done(b_done), .Busy(b_busy), .Sweep_count(b_sc)
  );

  typedef struct {
    logic       start, stop, dir, cont, en;
    logic [3:0] idx;
    logic [1:0] row, col;
    logic       valid, rf, rl, done, busy;
    logic [7:0] sc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic st, input logic sp, input logic d, input logic c,
                              input logic e, input int idx, input int r, input int cl,
                              input logic v, input logic rf, input logic rl, input logic dn,
                              input logic b, input int sc);
    vec_t t;
    t.start = st; t.stop = sp; t.dir = d; t.cont = c; t.en = e;
    t.idx = 4'(idx); t.row = 2'(r); t.col = 2'(cl);
    t.valid = v; t.rf = rf; t.rl = rl; t.done = dn; t.busy = b; t.sc = 8'(sc);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Dir = 1'b0; Continuous = 1'b0; Enable = 1'b0;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic go(input logic d, input logic c);
    Start = 1'b1; Dir = d; Continuous = c; Enable = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    int acc;
    int exp_i;
    bit finished;
    logic [3:0] pat;

    // Descending 4x3 scan with stalls and ignored mid-scan Dir/Continuous/Start changes
    vecs[0]  = mk(1,0,1,0,1, 11,2,3, 1,1,0,0,1,0);
    vecs[1]  = mk(0,0,0,1,1, 10,2,2, 1,0,0,0,1,0);
    vecs[2]  = mk(1,0,1,0,1,  9,2,1, 1,0,0,0,1,0);
    vecs[3]  = mk(0,0,1,0,1,  8,2,0, 1,0,1,0,1,0);
    vecs[4]  = mk(0,0,1,0,0,  8,2,0, 1,0,1,0,1,0);
    vecs[5]  = mk(0,0,1,0,0,  8,2,0, 1,0,1,0,1,0);
    vecs[6]  = mk(0,0,1,0,1,  7,1,3, 1,1,0,0,1,0);
    vecs[7]  = mk(0,0,1,0,1,  6,1,2, 1,0,0,0,1,0);
    vecs[8]  = mk(0,0,1,0,1,  5,1,1, 1,0,0,0,1,0);
    vecs[9]  = mk(0,0,1,0,1,  4,1,0, 1,0,1,0,1,0);
    vecs[10] = mk(0,0,1,0,1,  3,0,3, 1,1,0,0,1,0);
    vecs[11] = mk(0,0,1,0,1,  2,0,2, 1,0,0,0,1,0);
    vecs[12] = mk(0,0,1,0,1,  1,0,1, 1,0,0,0,1,0);
    vecs[13] = mk(0,0,1,0,1,  0,0,0, 1,0,1,0,1,0);
    vecs[14] = mk(0,0,1,0,1,  0,0,0, 0,0,1,1,0,1);
    vecs[15] = mk(0,0,1,0,1,  0,0,0, 0,0,1,0,0,1);

    do_reset();
    check("reset_a", {a_idx, a_row, a_col, a_valid, a_done, a_busy, a_sc}, 32'h0);
    check("reset_b", {b_idx, b_row, b_col, b_valid, b_done, b_busy, b_sc}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      Start = vecs[i].start; Stop = vecs[i].stop; Dir = vecs[i].dir;
      Continuous = vecs[i].cont; Enable = vecs[i].en;
      step();
      check($sformatf("vec%0d", i),
            {b_idx, b_row, b_col, b_valid, b_rf, b_rl, b_done, b_busy, b_sc},
            {vecs[i].idx, vecs[i].row, vecs[i].col, vecs[i].valid, vecs[i].rf,
             vecs[i].rl, vecs[i].done, vecs[i].busy, vecs[i].sc});
    end
    Start = 1'b0; Enable = 1'b0;

    // Full ascending 16x16 sweep
    do_reset();
    go(1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("asc_cell%0d", i), {a_valid, a_row, a_col, a_idx},
            {1'b1, 4'(i / 16), 4'(i % 16), 8'(i)});
      if (i % 16 == 0)  check("asc_row_first", {a_rf, a_rl}, 2'b10);
      if (i % 16 == 15) check("asc_row_last", {a_rf, a_rl}, 2'b01);
      step();
    end
    check("asc_end", {a_valid, a_done, a_busy, a_sc, a_idx}, {3'b010, 8'd1, 8'd255});
    step();
    check("asc_done_once", {a_valid, a_done, a_sc}, {2'b00, 8'd1});

    // Enable pattern 1,0,0,1 ascending: stalled cycles hold, every index accepted once
    do_reset();
    go(1'b0, 1'b0);
    pat = 4'b1001;
    acc = 0; exp_i = 0; finished = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      Enable = pat[3 - (k % 4)];
      check("stall_idx", {a_valid, a_idx}, {1'b1, 8'(exp_i)});
      if (Enable) begin acc++; exp_i++; end
      step();
      if (!a_valid) begin
        check("stall_done", {a_done, a_busy}, 2'b10);
        finished = 1'b1;
        break;
      end
    end
    check("stall_finished", 32'(finished), 32'd1);
    check("stall_accepts", 32'(acc), 32'd256);

    // Continuous 4x3 ascending, 30 accepts, no Valid gap
    do_reset();
    go(1'b0, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      check($sformatf("cont_cell%0d", c), {b_valid, b_idx}, {1'b1, 4'((c - 1) % 12)});
      step();
      check($sformatf("cont_done%0d", c), {b_done, b_busy}, {(c % 12 == 0), 1'b1});
    end
    check("cont_sweeps", 32'(b_sc), 32'd2);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check("cont_stop", {b_valid, b_busy, b_done, b_sc}, {3'b000, 8'd2});

    // Stop at idx 5
    do_reset();
    go(1'b0, 1'b0);
    repeat (5) step();
    check("stop5_pre", {a_valid, a_idx}, {1'b1, 8'd5});
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check("stop5", {a_valid, a_busy, a_done, a_sc}, {3'b000, 8'd0});
    step();
    check("stop5_after", {a_valid, a_done}, 2'b00);

    // Stop coincident with accept of the last cell
    do_reset();
    go(1'b0, 1'b0);
    repeat (255) step();
    check("stoplast_pre", {a_valid, a_idx}, {1'b1, 8'd255});
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check("stoplast", {a_valid, a_busy, a_done, a_sc}, {3'b000, 8'd0});
    step();
    check("stoplast_after", {a_valid, a_done, a_sc}, {2'b00, 8'd0});

    // Reset mid-scan at idx 100
    do_reset();
    go(1'b0, 1'b0);
    repeat (100) step();
    check("rst100_pre", {a_valid, a_idx}, {1'b1, 8'd100});
    Reset = 1'b1;
    step();
    check("rst100", {a_idx, a_row, a_col, a_valid, a_done, a_busy, a_sc}, 32'h0);
    Reset = 1'b0;
    step();
    check("rst100_after", {a_valid, a_done, a_busy}, 3'b000);

    // Start and Stop together in IDLE
    Start = 1'b1; Stop = 1'b1; Enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("startstop", {a_valid, a_busy, b_valid, b_busy}, 4'b0000);
    end
    Start = 1'b0; Stop = 1'b0;
    step();
    check("startstop_after", {a_valid, a_busy, a_sc}, {2'b00, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/grid_scan_counter.md
Name: grid_scan_counter

Overview:
- Parametrised lattice-coordinate generator for the LBM streaming/collision pipeline.
- Walks every cell of a GRID_W x GRID_H lattice in raster order, ascending or descending, and presents {Cell_idx, Row, Col} with a valid/enable handshake.
- Supports single-sweep or continuous (wrap-around) mode and counts completed sweeps, so the timestep controller can sequence iterations without an external counter.

Parameters:
- GRID_W, 16, lattice width in cells (>=2).
- GRID_H, 16, lattice height in cells (>=2).
- IDX_WIDTH, $clog2(GRID_W*GRID_H), cell index width.
- ROW_WIDTH, $clog2(GRID_H), row width.
- COL_WIDTH, $clog2(GRID_W), column width.
- SWEEP_WIDTH, 8, sweep counter width.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a scan; sampled only in IDLE.
- Stop  in  1  abort the scan; returns to IDLE without Done.
- Dir  in  1  0 = ascending (idx 0 to W*H-1); 1 = descending; latched at Start.
- Continuous  in  1  1 = wrap and rescan after the last cell; latched at Start.
- Enable  in  1  consumer ready; a cell is accepted when Valid & Enable.
- Cell_idx  out  IDX_WIDTH  current linear index, Row*GRID_W + Col.
- Row  out  ROW_WIDTH  current row.
- Col  out  COL_WIDTH  current column.
- Valid  out  1  coordinate outputs are meaningful.
- Row_first  out  1  current cell is the first of its row in scan order.
- Row_last  out  1  current cell is the last of its row in scan order.
- Done  out  1  one-cycle pulse after each completed sweep.
- Busy  out  1  FSM not in IDLE.
- Sweep_count  out  SWEEP_WIDTH  sweeps completed since the last Start.

Behaviour:
- Reset values: state IDLE; Cell_idx=0, Row=0, Col=0; Valid=0, Done=0, Busy=0, Sweep_count=0. Reset overrides all inputs.
- States are IDLE and SCAN. Outputs are registered except Row_first, Row_last and Valid.
  - Valid = (state==SCAN).
  - Row_first / Row_last are decoded from Col and the latched Dir.
- IDLE:
  - Start=1 & Stop=0 -> SCAN next cycle.
  - On that edge: latch Dir and Continuous, clear Sweep_count, load the first cell.
    - Ascending first cell: Row=0, Col=0, idx=0.
    - Descending first cell: Row=GRID_H-1, Col=GRID_W-1, idx=GRID_W*GRID_H-1.
  - Start & Stop in the same cycle: Stop wins, FSM stays IDLE.
- SCAN:
  - Valid & Enable=0: hold all outputs (stall).
  - Valid & Enable=1, not the last cell:
    - Ascending: Col+1; at Col=GRID_W-1, Col=0 and Row+1.
    - Descending: Col-1; at Col=0, Col=GRID_W-1 and Row-1.
    - Cell_idx moves +1 or -1 in step. It is kept as its own counter, with no multiplier.
  - Accept of the last cell (ascending W*H-1 / descending 0):
    - Done=1 in the next cycle, for exactly one cycle.
    - Sweep_count+1, wrapping modulo 2^SWEEP_WIDTH.
    - Continuous=1: reload the first cell and stay in SCAN. Valid stays high, with no bubble.
    - Continuous=0: go to IDLE. Valid=0 next cycle. Coordinates hold the last cell.
- Row flags:
  - Ascending: Row_first = (Col==0), Row_last = (Col==GRID_W-1).
  - Descending: Row_first = (Col==GRID_W-1), Row_last = (Col==0).
- Stop=1 in SCAN:
  - IDLE next cycle, no Done pulse, Sweep_count unchanged.
  - Stop takes priority over a simultaneous last-cell accept.
- Start in SCAN is ignored. Changes on Dir or Continuous mid-scan are ignored.
- Reset mid-scan: next cycle matches the reset values; Done is suppressed.
- Busy = (state==SCAN) registered. Busy is low during the Done cycle unless Continuous=1.

Test Plan:
- Reset, then Start with Dir=0, Continuous=0, Enable=1, default 16x16 -> Cell_idx runs 0..255 over 256 cycles; Row increments at Col 15 -> 0; Done is high for one cycle after idx 255; Valid=0 after that; Sweep_count=1.
- GRID_W=4, GRID_H=3, Dir=1 -> sequence idx 11..0; (Row,Col) starts (2,3), then (2,2)..(2,0), (1,3)...; Row_first=1 at Col=3; Row_last=1 at Col=0; Done after idx 0.
- Enable toggling 1,0,0,1 during an ascending scan -> outputs hold across the stalled cycles; no index is skipped or duplicated; the total accept count equals 256.
- Continuous=1, 4x3 grid, Enable=1 for 30 cycles -> idx wraps 11 -> 0 with no Valid gap; Done pulses after cycles 12 and 24; Sweep_count reads 2.
- Stop asserted at idx 5; separately, Stop in the same cycle as the accept of idx 255 -> IDLE next cycle; no Done pulse; Sweep_count=0.
- Reset high at idx 100 mid-scan; separately, Start and Stop together in IDLE -> after reset, all outputs read 0 and Busy=0; with Start and Stop together, the FSM stays IDLE and Valid never rises.
